msrv32_integer_file: RTL



---
 rtl/msrv32_integer_file.sv | 59 +++++
 1 files changed

// File: rtl/msrv32_integer_file.sv
// Integer register file x0..x31: two combinational read ports with write-through bypass,
// one synchronous write port from write-back. x0 is hardwired to zero and has no storage.
module msrv32_integer_file #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic [ADDR_W-1:0] rs_1_addr_in,
    input  logic [ADDR_W-1:0] rs_2_addr_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic              wr_en_in,
    input  logic [DATA_W-1:0] rd_in,
    output logic [DATA_W-1:0] rs_1_out,
    output logic [DATA_W-1:0] rs_2_out
);

    localparam logic [ADDR_W-1:0] X0_ADDR = ADDR_W'(0);

    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
    logic              wr_commit;

    assign wr_commit = wr_en_in && (rd_addr_in != X0_ADDR);

    // Reset wins over a same-edge write so a flushed/reset cycle never leaves stale data.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[rd_addr_in] <= rd_in;
        end
    end

    // Priority per port: reset, then x0, then bypass of the value being written back.
    always_comb begin
        rs_1_out = '0;
        rs_2_out = '0;
        if (!ms_riscv32_mp_rst_in) begin
            if (rs_1_addr_in != X0_ADDR) begin
                if (wr_en_in && (rd_addr_in == rs_1_addr_in)) begin
                    rs_1_out = rd_in;
                end else begin
                    rs_1_out = regs_q[rs_1_addr_in];
                end
            end
            if (rs_2_addr_in != X0_ADDR) begin
                if (wr_en_in && (rd_addr_in == rs_2_addr_in)) begin
                    rs_2_out = rd_in;
                end else begin
                    rs_2_out = regs_q[rs_2_addr_in];
                end
            end
        end
    end

endmodule
